// File: rtl/grf_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grf_pkg
//   Shared constants and helpers for the general register file with
//   pending scoreboard.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package grf_pkg;

  // Default geometry
  localparam int GRF_DW  = 32;
  localparam int GRF_AW  = 5;
  localparam int GRF_NRD = 2;

  // Widest packed vector the slice helper accepts
  localparam int GRF_SLICE_MAX = 1024;

  // Write-log line: time, register number, data
  localparam string GRF_LOG_FMT = "@%0t: $%0d <= %h";

  // Extract field idx of width w from a packed vector (result zero-extended)
  function automatic logic [63:0] grf_slice(input logic [GRF_SLICE_MAX-1:0] vec,
                                            input int idx, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return 64'(vec >> (idx * w)) & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/grf_pend_tracker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grf_pend_tracker
//   Per-register pending bits for results still in flight on the late write
//   port, a running count of set bits, and per-read-port busy flags.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module grf_pend_tracker
  import grf_pkg::*;
#(
  parameter int AW  = GRF_AW,
  parameter int NRD = GRF_NRD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_en,
  input  logic [AW-1:0]       clr_addr,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD-1:0]      rd_busy,
  output logic [(1<<AW)-1:0]  pend_vec,
  output logic [AW:0]         pend_cnt
);

  logic [(1<<AW)-1:0] pend_vec_q, pend_vec_d;
  logic [AW:0]        pend_cnt_q, pend_cnt_d;
  logic               set_hit;
  logic               clr_hit;
  logic               cnt_inc;
  logic               cnt_dec;

  // Next pending state: clear first, then set, so a same-address set wins
  always_comb begin
    set_hit    = rsv_en && (rsv_addr != '0);
    clr_hit    = clr_en && (clr_addr != '0);
    pend_vec_d = pend_vec_q;
    if (clr_hit) pend_vec_d[clr_addr] = 1'b0;
    if (set_hit) pend_vec_d[rsv_addr] = 1'b1;
    // Count only genuine 0->1 and 1->0 transitions
    cnt_inc    = set_hit && !pend_vec_q[rsv_addr];
    cnt_dec    = clr_hit && pend_vec_q[clr_addr] &&
                 !(set_hit && (rsv_addr == clr_addr));
    pend_cnt_d = pend_cnt_q + (AW+1)'(cnt_inc) - (AW+1)'(cnt_dec);
  end

  // Pending state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vec_q <= '0;
      pend_cnt_q <= '0;
    end else begin
      pend_vec_q <= pend_vec_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_vec = pend_vec_q;
  assign pend_cnt = pend_cnt_q;

  // Busy per read port; a result landing this cycle is bypassed instead
  for (genvar i = 0; i < NRD; i++) begin : g_busy
    logic [AW-1:0] a;
    assign a = AW'(grf_slice(GRF_SLICE_MAX'(rd_addr), i, AW));
    assign rd_busy[i] = !rst && (a != '0) && pend_vec_q[a] &&
                        !(clr_en && (clr_addr == a));
  end

endmodule
`default_nettype wire

// File: rtl/grf_mp_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// grf_mp_scoreboard
//   General register file: NRD combinational read ports with write-through
//   bypass, an in-order write port (0), a late write port (1) and an
//   integrated pending scoreboard for port-1 results.
//   Optional: define GRF_WRITE_LOG_EN to print every committed write.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module grf_mp_scoreboard
  import grf_pkg::*;
#(
  parameter int DW  = GRF_DW,
  parameter int AW  = GRF_AW,
  parameter int NRD = GRF_NRD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic [(1<<AW)-1:0]  pend_vec,
  output logic [AW:0]         pend_cnt
);

  localparam int NREG = 1 << AW;

  logic [DW-1:0] mem_q [NREG];
  logic [DW-1:0] mem_d [NREG];
  logic          w0_commit;
  logic          w1_commit;

  // Commit qualification: register 0 is never written, port 0 wins collisions
  always_comb begin
    w0_commit = we0 && (wa0 != '0);
    w1_commit = we1 && (wa1 != '0) && !(w0_commit && (wa0 == wa1));
  end

  // Next array contents
  always_comb begin
    mem_d = mem_q;
    if (w1_commit) mem_d[wa1] = wd1;
    if (w0_commit) mem_d[wa0] = wd0;
  end

  // Register array storage
  always_ff @(posedge clk) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

  // Read ports with write-through bypass; bypass is off during reset
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    assign a = AW'(grf_slice(GRF_SLICE_MAX'(rd_addr), i, AW));
    // Priority: r0, port 0 bypass, port 1 bypass, array
    always_comb begin
      if (a == '0)                         d = '0;
      else if (!rst && we0 && (wa0 == a))  d = wd0;
      else if (!rst && we1 && (wa1 == a))  d = wd1;
      else                                 d = mem_q[a];
    end
    assign rd_data[i*DW +: DW] = d;
  end

  // Pending scoreboard: reserve from decode, clear on late writeback
  grf_pend_tracker #(
    .AW  (AW),
    .NRD (NRD)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_en   (we1),
    .clr_addr (wa1),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .pend_vec (pend_vec),
    .pend_cnt (pend_cnt)
  );

`ifdef GRF_WRITE_LOG_EN
  // Trace committed writes, port 0 first
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w0_commit) $display(GRF_LOG_FMT, $time, wa0, wd0);
      if (w1_commit) $display(GRF_LOG_FMT, $time, wa1, wd1);
    end
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_grf_mp_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_grf_mp_scoreboard
//   Directed vector table, scoreboard corner sequences and randomized
//   traffic against a behavioural register-file model.
//   Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_grf_mp_scoreboard;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NRD = 2;
  localparam int NR = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   ra0, ra1;
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*DW-1:0] rd_data;
  logic [NRD-1:0]  rd_busy;
  logic            we0, we1, rsv_en;
  logic [AW-1:0]   wa0, wa1, rsv_addr;
  logic [DW-1:0]   wd0, wd1;
  logic [NR-1:0]   pend_vec;
  logic [AW:0]     pend_cnt;

  assign rd_addr = {ra1, ra0};

  always #5 clk = ~clk;

  grf_mp_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1),
    .wa1(wa1), .wd1(wd1), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .pend_vec(pend_vec), .pend_cnt(pend_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model
  logic [DW-1:0] m_reg [NR];
  bit            m_pend [NR];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] m_read(input int a);
    if (a == 0) return '0;
    if (!rst && we0 && wa0 == a) return wd0;
    if (!rst && we1 && wa1 == a) return wd1;
    return m_reg[a];
  endfunction

  function automatic logic m_busy(input int a);
    return !rst && a != 0 && m_pend[a] && !(we1 && wa1 == a);
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int k = 0; k < NR; k++) c += m_pend[k] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [NR-1:0] m_vec();
    logic [NR-1:0] v;
    for (int k = 0; k < NR; k++) v[k] = m_pend[k];
    return v;
  endfunction

  // Apply one clock edge to the model using the current inputs
  task automatic model_edge();
    if (rst) begin
      for (int k = 0; k < NR; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
    end else begin
      if (we1 && wa1 != 0 && !(we0 && wa0 == wa1)) m_reg[wa1] = wd1;
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) m_pend[wa1] = 0;
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1;
    end
  endtask

  task automatic idle_inputs();
    we0 = 0; wa0 = '0; wd0 = '0; we1 = 0; wa1 = '0; wd1 = '0;
    rsv_en = 0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic          we0; logic [AW-1:0] wa0; logic [DW-1:0] wd0;
    logic          we1; logic [AW-1:0] wa1; logic [DW-1:0] wd1;
    logic          rsv; logic [AW-1:0] rsa;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e_rd0, e_rd1;
    logic [1:0]    e_busy;
    int            e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic w0, input int a0, input logic [DW-1:0] d0,
                              input logic w1, input int a1, input logic [DW-1:0] d1,
                              input logic rv, input int rs, input int r0, input int r1,
                              input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                              input logic [1:0] eb, input int ec);
    vec_t v;
    v.we0 = w0; v.wa0 = AW'(a0); v.wd0 = d0;
    v.we1 = w1; v.wa1 = AW'(a1); v.wd1 = d1;
    v.rsv = rv; v.rsa = AW'(rs);
    v.ra0 = AW'(r0); v.ra1 = AW'(r1);
    v.e_rd0 = e0; v.e_rd1 = e1; v.e_busy = eb; v.e_cnt = ec;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    // Directed table, applied in order starting from a clean reset
    tbl.push_back(mk(1, 5, 32'h1234, 0, 0, 0,        0, 0,  5, 0,  32'h1234, 32'h0,    2'b00, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0,  5, 9,  32'h1234, 32'h0,    2'b00, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1, 9,  9, 7,  32'h0,    32'h0,    2'b00, 1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0,  9, 9,  32'h0,    32'h0,    2'b11, 1));
    tbl.push_back(mk(0, 0, 0,        1, 9, 32'h55,   0, 0,  9, 9,  32'h55,   32'h55,   2'b00, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1, 7,  7, 5,  32'h0,    32'h1234, 2'b00, 1));
    tbl.push_back(mk(1, 7, 32'hAAAA, 1, 7, 32'hBBBB, 0, 0,  7, 9,  32'hAAAA, 32'h55,   2'b00, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0,  7, 7,  32'hAAAA, 32'hAAAA, 2'b00, 0));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        1, 3,  3, 0,  32'h0,    32'h0,    2'b00, 1));
    tbl.push_back(mk(0, 0, 0,        1, 3, 32'h33,   1, 3,  3, 3,  32'h33,   32'h33,   2'b00, 1));
    tbl.push_back(mk(0, 0, 0,        0, 0, 0,        0, 0,  3, 9,  32'h33,   32'h55,   2'b01, 1));
    tbl.push_back(mk(1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0,  0, 3,  32'h0,    32'h33,   2'b10, 1));
    tbl.push_back(mk(1, 3, 32'h77,   0, 0, 0,        0, 0,  3, 0,  32'h77,   32'h0,    2'b01, 1));
    tbl.push_back(mk(0, 0, 0,        1, 3, 32'h0,    0, 0,  3, 7,  32'h0,    32'hAAAA, 2'b00, 0));

    for (int k = 0; k < NR; k++) begin m_reg[k] = '0; m_pend[k] = 0; end
    idle_inputs();
    ra0 = '0; ra1 = '0;
    rst = 1;

    // Reset and sweep every address
    tick(); tick();
    @(negedge clk); rst = 0;
    #1;
    check("reset_pend_vec", 64'(pend_vec), 64'(0));
    check("reset_pend_cnt", 64'(pend_cnt), 64'(0));
    for (int a = 0; a < NR; a++) begin
      @(negedge clk);
      ra0 = AW'(a); ra1 = AW'(NR - 1 - a);
      #1;
      check("reset_rd0", 64'(rd_data[31:0]), 64'(0));
      check("reset_rd1", 64'(rd_data[63:32]), 64'(0));
    end

    // Directed table
    foreach (tbl[n]) begin
      @(negedge clk);
      we0 = tbl[n].we0; wa0 = tbl[n].wa0; wd0 = tbl[n].wd0;
      we1 = tbl[n].we1; wa1 = tbl[n].wa1; wd1 = tbl[n].wd1;
      rsv_en = tbl[n].rsv; rsv_addr = tbl[n].rsa;
      ra0 = tbl[n].ra0; ra1 = tbl[n].ra1;
      #1;
      check($sformatf("tbl%0d_rd0", n), 64'(rd_data[31:0]), 64'(tbl[n].e_rd0));
      check($sformatf("tbl%0d_rd1", n), 64'(rd_data[63:32]), 64'(tbl[n].e_rd1));
      check($sformatf("tbl%0d_busy", n), 64'(rd_busy), 64'(tbl[n].e_busy));
      tick();
      check($sformatf("tbl%0d_cnt", n), 64'(pend_cnt), 64'(tbl[n].e_cnt));
    end

    // Fill: reserve every register, then clear all via the late port
    for (int r = 1; r < NR; r++) begin
      @(negedge clk);
      idle_inputs(); rsv_en = 1; rsv_addr = AW'(r);
      tick();
    end
    @(negedge clk); idle_inputs(); ra0 = 5'd31; ra1 = 5'd0;
    #1;
    check("fill_cnt", 64'(pend_cnt), 64'(31));
    check("fill_vec", 64'(pend_vec), 64'(32'hFFFF_FFFE));
    check("fill_busy", 64'(rd_busy), 64'(2'b01));
    for (int r = 1; r < NR; r++) begin
      @(negedge clk);
      idle_inputs(); we1 = 1; wa1 = AW'(r); wd1 = 32'(r * 3);
      tick();
    end
    @(negedge clk); idle_inputs();
    #1;
    check("drain_cnt", 64'(pend_cnt), 64'(0));
    check("drain_vec", 64'(pend_vec), 64'(0));

    // Mid-stream reset: array visible, bypass and busy suppressed while rst=1
    rsv_en = 1; rsv_addr = 5'd12;
    tick();
    @(negedge clk);
    idle_inputs(); rst = 1;
    we0 = 1; wa0 = 5'd5; wd0 = 32'hFFFF; we1 = 1; wa1 = 5'd6; wd1 = 32'hEEEE;
    rsv_en = 1; rsv_addr = 5'd4;
    ra0 = 5'd5; ra1 = 5'd12;
    #1;
    check("rst_no_bypass", 64'(rd_data[31:0]), 64'(32'd15));
    check("rst_array12", 64'(rd_data[63:32]), 64'(32'd36));
    check("rst_busy", 64'(rd_busy), 64'(0));
    tick();
    check("rst_cnt", 64'(pend_cnt), 64'(0));
    check("rst_vec", 64'(pend_vec), 64'(0));
    @(negedge clk); idle_inputs(); rst = 0; ra0 = 5'd5; ra1 = 5'd6;
    #1;
    check("rst_clear5", 64'(rd_data[31:0]), 64'(0));
    check("rst_clear6", 64'(rd_data[63:32]), 64'(0));

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      int hi;
      @(negedge clk);
      hi = ($urandom_range(0, 3) == 0) ? 31 : 7;
      rst = ($urandom_range(0, 59) == 0);
      we0 = ($urandom_range(0, 1) == 1);
      wa0 = AW'($urandom_range(0, hi)); wd0 = $urandom;
      we1 = ($urandom_range(0, 9) < 4);
      wa1 = AW'($urandom_range(0, hi)); wd1 = $urandom;
      rsv_en = ($urandom_range(0, 9) < 4);
      rsv_addr = AW'($urandom_range(0, hi));
      ra0 = AW'($urandom_range(0, hi)); ra1 = AW'($urandom_range(0, hi));
      #1;
      check("rnd_rd0", 64'(rd_data[31:0]), 64'(m_read(int'(ra0))));
      check("rnd_rd1", 64'(rd_data[63:32]), 64'(m_read(int'(ra1))));
      check("rnd_busy0", 64'(rd_busy[0]), 64'(m_busy(int'(ra0))));
      check("rnd_busy1", 64'(rd_busy[1]), 64'(m_busy(int'(ra1))));
      tick();
      check("rnd_vec", 64'(pend_vec), 64'(m_vec()));
      check("rnd_cnt", 64'(pend_cnt), 64'(m_count()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
